// File: rtl/br_pred_nway.sv
// br_pred_nway: N-slot fetch-block branch predictor.
//   One BTB bank and one 2-bit PHT bank per slot, so every slot in a block
//   is looked up in parallel. The prediction is registered and appears one
//   cycle after the request. The branch unit trains the tables.
//   After reset an INIT phase clears every table, one index per cycle.
// Optional feature: define BR_PRED_RAS_EN to add a circular return stack.
//   A taken return slot then uses the top of the stack as its target.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid, req_pc          fetch request (pc may be mid-block)
//   ready                      0 while tables initialise
//   pred_valid/taken/slot      prediction strobe, any-taken, first taken slot
//   pred_type                  per-slot BTB type, 2 bits per slot, slot 0 in LSBs
//   pred_target                next fetch PC
//   upd_valid/pc/type/target   branch-unit training strobe and payload
//   upd_taken, upd_call        resolved direction; call marker for RAS push

// Per-slot bank: BTB entry arrays plus the PHT counters for one slot.
module br_pred_bank #(
  parameter int PC_W      = 30,
  parameter int TAG_W     = 10,
  parameter int BTB_DEPTH = 256,
  parameter int PHT_DEPTH = 512,
  parameter int BI        = $clog2(BTB_DEPTH),
  parameter int PI        = $clog2(PHT_DEPTH)
) (
  input  logic            clk,
  input  logic            init,
  input  logic [BI-1:0]   init_bidx,
  input  logic [PI-1:0]   init_pidx,
  input  logic [BI-1:0]   lk_bidx,
  input  logic [PI-1:0]   lk_pidx,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic            up_we,
  input  logic [BI-1:0]   up_bidx,
  input  logic [PI-1:0]   up_pidx,
  input  logic [TAG_W-1:0] up_tag,
  input  logic [1:0]      up_type,
  input  logic [PC_W-1:0] up_target,
  input  logic            up_taken,
  output logic            hit,
  output logic [1:0]      ent_type,
  output logic [PC_W-1:0] ent_target,
  output logic            pht_hi
);
  logic             vld [BTB_DEPTH];
  logic [TAG_W-1:0] tag [BTB_DEPTH];
  logic [1:0]       typ [BTB_DEPTH];
  logic [PC_W-1:0]  tgt [BTB_DEPTH];
  logic [1:0]       pht [PHT_DEPTH];

  logic [1:0] pht_cur, pht_nxt;

  // Reads are asynchronous so a same-cycle update is not seen by the lookup.
  assign hit        = vld[lk_bidx] && (tag[lk_bidx] == lk_tag);
  assign ent_type   = typ[lk_bidx];
  assign ent_target = tgt[lk_bidx];
  assign pht_hi     = pht[lk_pidx][1];

  assign pht_cur = pht[up_pidx];
  always_comb begin
    pht_nxt = pht_cur;
    if (up_taken) begin
      if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      vld[init_bidx] <= 1'b0;
      pht[init_pidx] <= 2'b01;
    end else if (up_we) begin
      vld[up_bidx] <= 1'b1;
      tag[up_bidx] <= up_tag;
      typ[up_bidx] <= up_type;
      tgt[up_bidx] <= up_target;
      if (up_type == 2'b01) pht[up_pidx] <= pht_nxt;
    end
  end
endmodule

module br_pred_nway #(
  parameter int PC_W      = 30,
  parameter int FETCH_W   = 2,
  parameter int BTB_DEPTH = 256,
  parameter int PHT_DEPTH = 512,
  parameter int TAG_W     = 10,
  parameter int RAS_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [PC_W-1:0]        req_pc,
  output logic                   ready,
  output logic                   pred_valid,
  output logic                   pred_taken,
  output logic [$clog2(FETCH_W)-1:0] pred_slot,
  output logic [FETCH_W*2-1:0]   pred_type,
  output logic [PC_W-1:0]        pred_target,
  input  logic                   upd_valid,
  input  logic [PC_W-1:0]        upd_pc,
  input  logic [1:0]             upd_type,
  input  logic [PC_W-1:0]        upd_target,
  input  logic                   upd_taken,
  input  logic                   upd_call
);
  localparam int S    = $clog2(FETCH_W);
  localparam int BI   = $clog2(BTB_DEPTH);
  localparam int PI   = $clog2(PHT_DEPTH);
  localparam int MAXD = (BTB_DEPTH > PHT_DEPTH) ? BTB_DEPTH : PHT_DEPTH;
  localparam int CW   = $clog2(MAXD);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic                      valid;
    logic                      taken;
    logic [S-1:0]              slot;
    logic [FETCH_W-1:0][1:0]   types;
    logic [PC_W-1:0]           target;
  } pred_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MAXD - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  assign ready  = (state_q == RUN);
  // Nothing trains or predicts in the cycle reset is asserted.
  assign run_ok = ready && !rst;

  // All slots of a block share index and tag; only the bank differs.
  logic [BI-1:0]    lk_bidx, up_bidx;
  logic [PI-1:0]    lk_pidx, up_pidx;
  logic [TAG_W-1:0] lk_tag,  up_tag;

  assign lk_bidx = req_pc[S +: BI];
  assign lk_pidx = req_pc[S +: PI];
  assign lk_tag  = req_pc[S+BI +: TAG_W];
  assign up_bidx = upd_pc[S +: BI];
  assign up_pidx = upd_pc[S +: PI];
  assign up_tag  = upd_pc[S+BI +: TAG_W];

  logic [FETCH_W-1:0]           b_hit, b_pht, b_we;
  logic [FETCH_W-1:0][1:0]      b_type;
  logic [FETCH_W-1:0][PC_W-1:0] b_tgt;

  for (genvar g = 0; g < FETCH_W; g++) begin : g_bank
    assign b_we[g] = upd_valid && run_ok && (upd_type != 2'b00) &&
                     (upd_pc[S-1:0] == S'(g));
    br_pred_bank #(
      .PC_W(PC_W), .TAG_W(TAG_W), .BTB_DEPTH(BTB_DEPTH), .PHT_DEPTH(PHT_DEPTH)
    ) u_bank (
      .clk       (clk),
      .init      (state_q == INIT),
      .init_bidx (cnt_q[BI-1:0]),
      .init_pidx (cnt_q[PI-1:0]),
      .lk_bidx   (lk_bidx),
      .lk_pidx   (lk_pidx),
      .lk_tag    (lk_tag),
      .up_we     (b_we[g]),
      .up_bidx   (up_bidx),
      .up_pidx   (up_pidx),
      .up_tag    (up_tag),
      .up_type   (upd_type),
      .up_target (upd_target),
      .up_taken  (upd_taken),
      .hit       (b_hit[g]),
      .ent_type  (b_type[g]),
      .ent_target(b_tgt[g]),
      .pht_hi    (b_pht[g])
    );
  end

  logic [PC_W-1:0] ras_top;
  logic            ras_ok;

`ifdef BR_PRED_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);
  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [RW-1:0]   ras_ptr;   // next free slot
  logic [RW:0]     ras_cnt;
  logic            push, pop;

  assign push = upd_valid && run_ok && (upd_type == 2'b10) && upd_call;
  assign pop  = upd_valid && run_ok && (upd_type == 2'b11);

  always_ff @(posedge clk) begin
    if (rst || state_q == INIT) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push) begin
      // A full stack wraps and overwrites the oldest link.
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != (RW+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end else if (pop && ras_cnt != '0) begin
      ras_ptr <= ras_ptr - 1'b1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras[ras_ptr] <= upd_pc + 1'b1;
  end

  assign ras_top = ras[ras_ptr - 1'b1];
  assign ras_ok  = (ras_cnt != '0);
`else
  assign ras_top = '0;
  assign ras_ok  = 1'b0;
  wire unused_upd = ^{upd_call, upd_pc};
`endif

  pred_t nxt, pred_q;

  // Walk slots high to low so the lowest taken slot wins.
  always_comb begin
    nxt        = '0;
    nxt.valid  = 1'b1;
    nxt.target = {req_pc[PC_W-1:S], {S{1'b0}}} + PC_W'(FETCH_W);
    for (int i = FETCH_W - 1; i >= 0; i--) begin
      if (S'(i) >= req_pc[S-1:0] && b_hit[i]) begin
        nxt.types[i] = b_type[i];
        if (b_type[i] != 2'b01 || b_pht[i]) begin
          nxt.taken  = 1'b1;
          nxt.slot   = S'(i);
          nxt.target = (b_type[i] == 2'b11 && ras_ok) ? ras_top : b_tgt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      pred_q       <= '0;
    else if (req_valid && run_ok) pred_q       <= nxt;
    else                          pred_q.valid <= 1'b0;
  end

  assign pred_valid  = pred_q.valid;
  assign pred_taken  = pred_q.taken;
  assign pred_slot   = pred_q.slot;
  assign pred_type   = pred_q.types;
  assign pred_target = pred_q.target;
endmodule
